// File: rtl/ffl_round_controller.sv
// ffl_round_controller: one fastest-finger round sequencer.
// Synchronises and edge-detects the player buttons, arbitrates the first
// eligible press, runs the answer timer, applies host judgement and keeps
// saturating per-player scores.
// Optional feature macro: FALSE_START_EN. When it is defined, presses made
// while IDLE are remembered and those players are barred from the next round.
//
// Handshake note: host_start / host_correct / host_wrong / tick are one-cycle
// strobes with no back-pressure. A strobe takes effect on the clock edge where
// it is high, and only in the state that accepts it. In any other state it is
// dropped.
module ffl_round_controller #(
  parameter int ANSWER_TICKS = 200,
  parameter int SCORE_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 host_start,
  input  logic                 host_correct,
  input  logic                 host_wrong,
  input  logic [3:0]           player,
  output logic                 flag,
  output logic [1:0]           winner_id,
  output logic [3:0]           winner_onehot,
  output logic [1:0]           state,
  output logic [7:0]           time_left,
  output logic                 timeout,
  output logic [3:0]           excluded,
  output logic [4*SCORE_W-1:0] score
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

  logic [3:0]           sync1_q, sync2_q, prev_q, edge_q;
  state_e               state_q, state_d;
  logic [1:0]           winner_q, winner_d;
  logic [7:0]           time_q, time_d;
  logic [3:0]           excl_q, excl_d;
  logic [4*SCORE_W-1:0] score_q, score_d;
  logic [3:0]           elig;
  logic [1:0]           pick_id;
  logic [3:0]           win_oh;
  logic [3:0]           excl_hit;
  logic [SCORE_W-1:0]   cur_score;
`ifdef FALSE_START_EN
  logic [3:0]           pending_q, pending_d;
`endif

  // Two-flop synchroniser, previous-sample register and registered rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'b0;
      sync2_q <= 4'b0;
      prev_q  <= 4'b0;
      edge_q  <= 4'b0;
    end else begin
      sync1_q <= player;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= sync2_q & ~prev_q;
    end
  end

  // Fixed-priority pick among eligible edges: lowest index wins
  always_comb begin
    elig    = edge_q & ~excl_q;
    pick_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (elig[i]) pick_id = 2'(i);
    end
  end

  assign win_oh    = 4'b0001 << winner_q;
  assign excl_hit  = excl_q | win_oh;
  assign cur_score = score_q[winner_q*SCORE_W +: SCORE_W];

  // Round FSM: next state, timer, exclusion and score updates
  always_comb begin
    state_d = state_q;
    winner_d = winner_q;
    time_d   = time_q;
    excl_d   = excl_q;
    score_d  = score_q;
    timeout  = 1'b0;
`ifdef FALSE_START_EN
    pending_d = pending_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef FALSE_START_EN
        pending_d = pending_q | edge_q;
`endif
        if (host_start) begin
          state_d = ST_ARMED;
`ifdef FALSE_START_EN
          excl_d    = pending_q;
          pending_d = 4'b0;
`else
          excl_d = 4'b0;
`endif
        end
      end
      ST_ARMED: begin
        if (|elig) begin
          state_d  = ST_LOCKED;
          winner_d = pick_id;
          time_d   = 8'(ANSWER_TICKS);
        end
      end
      ST_LOCKED: begin
        if (host_correct) begin
          if (cur_score != SCORE_MAX) begin
            score_d[winner_q*SCORE_W +: SCORE_W] = cur_score + SCORE_ONE;
          end
          state_d = ST_IDLE;
          time_d  = 8'd0;
        end else if (host_wrong || (tick && (time_q == 8'd0))) begin
          timeout = ~host_wrong;
          excl_d  = excl_hit;
          state_d = (&excl_hit) ? ST_IDLE : ST_ARMED;
          time_d  = 8'd0;
        end else if (tick && (time_q != 8'd0)) begin
          time_d = time_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        time_d  = 8'd0;
      end
    endcase
  end

  // Round state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      winner_q <= 2'd0;
      time_q   <= 8'd0;
      excl_q   <= 4'b0;
      score_q  <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      time_q   <= time_d;
      excl_q   <= excl_d;
      score_q  <= score_d;
    end
  end

`ifdef FALSE_START_EN
  // False-start memory, only written while IDLE
  always_ff @(posedge clk) begin
    if (rst) pending_q <= 4'b0;
    else     pending_q <= pending_d;
  end
`endif

  assign flag          = (state_q == ST_LOCKED);
  assign winner_id     = winner_q;
  assign winner_onehot = flag ? win_oh : 4'b0;
  assign state         = state_q;
  assign time_left     = time_q;
  assign excluded      = excl_q;
  assign score         = score_q;

endmodule

// File: tb/tb_ffl_round_controller.sv
// Bench for ffl_round_controller: directed round scenarios followed by a
// random phase, all checked against a round-level reference model.
module tb_ffl_round_controller;

  localparam int T  = 3;
  localparam int SW = 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk;
  logic rst, tick, host_start, host_correct, host_wrong;
  logic [3:0] player;
  logic flag, timeout;
  logic [1:0] winner_id, state;
  logic [3:0] winner_onehot, excluded;
  logic [7:0] time_left;
  logic [4*SW-1:0] score;

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ffl_round_controller #(.ANSWER_TICKS(T), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .host_start(host_start),
    .host_correct(host_correct), .host_wrong(host_wrong), .player(player),
    .flag(flag), .winner_id(winner_id), .winner_onehot(winner_onehot),
    .state(state), .time_left(time_left), .timeout(timeout),
    .excluded(excluded), .score(score)
  );

  // ---------------- reference model ----------------
  // Round-level view: a press is seen by the arbiter three edges after the
  // edge that first samples it (hist holds the last four samples).
  int         m_state = 0;
  int         m_wid   = 0;
  int         m_time  = 0;
  logic [3:0] m_excl  = 4'b0;
  logic [3:0] m_pend  = 4'b0;
  int         m_score[4] = '{0, 0, 0, 0};
  logic [3:0] hist[4] = '{4'b0, 4'b0, 4'b0, 4'b0};

  always @(posedge clk) begin
    logic [3:0] ev;
    logic [3:0] cand;
    if (rst) begin
      m_state = 0; m_wid = 0; m_time = 0; m_excl = 4'b0; m_pend = 4'b0;
      for (int i = 0; i < 4; i++) begin m_score[i] = 0; hist[i] = 4'b0; end
    end else begin
      ev = hist[2] & ~hist[3];
      if (m_state == 0) begin
        if (host_start) begin
          m_state = 1;
`ifdef FALSE_START_EN
          m_excl = m_pend;
          m_pend = 4'b0;
`else
          m_excl = 4'b0;
`endif
        end else begin
`ifdef FALSE_START_EN
          m_pend = m_pend | ev;
`endif
        end
      end else if (m_state == 1) begin
        cand = ev & ~m_excl;
        if (cand != 4'b0) begin
          for (int i = 0; i < 4; i++) begin
            if (cand[i]) begin m_wid = i; break; end
          end
          m_state = 2;
          m_time = T;
        end
      end else begin
        if (host_correct) begin
          if (m_score[m_wid] < (1 << SW) - 1) m_score[m_wid] = m_score[m_wid] + 1;
          m_state = 0;
          m_time = 0;
        end else if (host_wrong || (tick && m_time == 0)) begin
          m_excl[m_wid] = 1'b1;
          m_state = (m_excl == 4'hf) ? 0 : 1;
          m_time = 0;
        end else if (tick && m_time > 0) begin
          m_time = m_time - 1;
        end
      end
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = player;
    end
  end

  function automatic logic exp_timeout();
    return (m_state == 2) && tick && (m_time == 0) && !host_correct && !host_wrong;
  endfunction

  function automatic logic [4*SW-1:0] exp_score();
    logic [4*SW-1:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) s[i*SW +: SW] = SW'(m_score[i]);
    return s;
  endfunction

  // ---------------- scoreboard / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check the combinational pulse, take the edge, check registers,
  // then drop all strobes.
  task automatic cyc();
    #1;
    check("timeout", {31'b0, timeout}, {31'b0, exp_timeout()});
    @(posedge clk); #1;
    check("state", {30'b0, state}, m_state);
    check("winner_id", {30'b0, winner_id}, m_wid);
    check("winner_onehot", {28'b0, winner_onehot}, (m_state == 2) ? (32'd1 << m_wid) : 32'd0);
    check("flag", {31'b0, flag}, {31'b0, (m_state == 2)});
    check("time_left", {24'b0, time_left}, m_time);
    check("excluded", {28'b0, excluded}, {28'b0, m_excl});
    check("score", 32'(score), 32'(exp_score()));
    host_start = 0; host_correct = 0; host_wrong = 0; tick = 0; rst = 0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // ---------------- stimulus ----------------
  int exp_sat[4] = '{1, 2, 3, 3};

  initial begin
    rst = 1; tick = 0; host_start = 0; host_correct = 0; host_wrong = 0; player = 4'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    cyc();
    check("reset_state", {30'b0, state}, 0);
    check("reset_score", 32'(score), 0);

    // First round: player 1 locks after three synchroniser/detect edges
    host_start = 1; cyc();
    check("armed", {30'b0, state}, 1);
    player = 4'b0010; cycles(3);
    check("not_yet_locked", {30'b0, state}, 1);
    cyc();
    check("lock_state", {30'b0, state}, 2);
    check("lock_wid", {30'b0, winner_id}, 1);
    check("lock_onehot", {28'b0, winner_onehot}, 4'b0010);
    check("lock_time", {24'b0, time_left}, T);
    player = 4'b0011; cycles(2);
    player = 4'b0111; cycles(4);
    check("locked_ignores", {30'b0, winner_id}, 1);
    player = 4'b0; host_correct = 1; cyc();
    check("score1", {30'b0, score[1*SW +: SW]}, 1);
    cycles(4);

    // Saturating score for player 0
    for (int k = 0; k < 4; k++) begin
      host_start = 1; cyc();
      player = 4'b0001; cycles(4);
      check("sat_wid", {30'b0, winner_id}, 0);
      host_correct = 1; cyc();
      check("sat_score0", {30'b0, score[0 +: SW]}, exp_sat[k]);
      player = 4'b0; cycles(3);
    end

    // Wrong answer, rebound, excluded player re-press ignored
    host_start = 1; cyc();
    player = 4'b0001; cycles(4);
    host_wrong = 1; cyc();
    check("wrong_excl", {28'b0, excluded}, 4'b0001);
    check("wrong_rebound", {30'b0, state}, 1);
    player = 4'b0; cycles(2);
    player = 4'b0001; cycles(5);
    check("excl_ignored", {30'b0, state}, 1);
    player = 4'b0101; cycles(4);
    check("rebound_wid", {30'b0, winner_id}, 2);
    host_correct = 1; cyc();
    check("score2", {30'b0, score[2*SW +: SW]}, 1);
    player = 4'b0; cycles(3);

    // Simultaneous presses, then correct+wrong together counts as correct
    host_start = 1; cyc();
    player = 4'b1100; cycles(4);
    check("simul_wid", {30'b0, winner_id}, 2);
    host_correct = 1; host_wrong = 1; cyc();
    check("both_state", {30'b0, state}, 0);
    check("both_score2", {30'b0, score[2*SW +: SW]}, 2);
    player = 4'b0; cycles(3);

    // Answer timer expiry
    host_start = 1; cyc();
    player = 4'b0010; cycles(4);
    player = 4'b0;
    for (int k = 0; k < T; k++) begin tick = 1; cyc(); end
    check("timer_zero", {24'b0, time_left}, 0);
    tick = 1; #1;
    check("timeout_pulse", {31'b0, timeout}, 1);
    cyc();
    check("to_excl", {28'b0, excluded}, 4'b0010);
    check("to_state", {30'b0, state}, 1);

    // Reset clears scores; false-start handling
    rst = 1; cyc();
    check("rst_score", 32'(score), 0);
    player = 4'b0100; cycles(5);
    player = 4'b0; cycles(4);
    host_start = 1; cyc();
`ifdef FALSE_START_EN
    check("fs_excl", {28'b0, excluded}, 4'b0100);
`else
    check("fs_excl", {28'b0, excluded}, 4'b0000);
`endif
    player = 4'b0110; cycles(4);
    check("fs_lock", {30'b0, state}, 2);
    check("fs_wid", {30'b0, winner_id}, 1);
    rst = 1; cyc();
    check("midrst_state", {30'b0, state}, 0);
    check("midrst_flag", {31'b0, flag}, 0);
    check("midrst_onehot", {28'b0, winner_onehot}, 0);
    check("midrst_time", {24'b0, time_left}, 0);
    check("midrst_excl", {28'b0, excluded}, 0);
    player = 4'b0; cycles(3);

    // Random phase against the model
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) player[b] = ~player[b];
      end
      tick         = ($urandom_range(0, 1) == 1);
      host_start   = ($urandom_range(0, 4) == 0);
      host_correct = ($urandom_range(0, 9) == 0);
      host_wrong   = ($urandom_range(0, 7) == 0);
      rst          = ($urandom_range(0, 149) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
